// File: rtl/arbiter_4_rr_sched_pkg.sv
// Shared types and defaults for the round-robin resource scheduler.
package arbiter_4_rr_sched_pkg;

  localparam int N_DEFAULT        = 4;
  localparam int MAX_HOLD_DEFAULT = 16;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_t;

endpackage : arbiter_4_rr_sched_pkg

// File: rtl/arbiter_4_rr_sched_rr_pick.sv
// Cyclic priority picker: first set request at or after ptr, wrapping at N.
module arbiter_4_rr_sched_rr_pick
  import arbiter_4_rr_sched_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  assign valid = |req;

  // Scan from the farthest offset down so the offset closest to ptr wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) idx = PW'((int'(ptr) + k) % N);
    end
  end

endmodule : arbiter_4_rr_sched_rr_pick

// File: rtl/arbiter_4_rr_sched.sv
// Round-robin scheduler granting one shared resource to one of N requesters,
// holding the grant until done/req drop or the optional hold timeout.
module arbiter_4_rr_sched
  import arbiter_4_rr_sched_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N-1:0]                      req,
  input  logic [N-1:0]                      done,
  output logic [N-1:0]                      gnt,
  output logic                              busy,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner_id,
  output logic                              timeout
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] CNT_SAT  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [PW-1:0] owner_nxt;
  logic          timeout_nxt;
  logic          pick_valid;
  logic [PW-1:0] pick_idx;
  logic          rel_normal;
  logic          rel_forced;

  arbiter_4_rr_sched_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // A normal release always wins over a timeout landing on the same edge.
  assign rel_normal = done[owner_id] | ~req[owner_id];
  assign rel_forced = (MAX_HOLD != 0) && (cnt == CNT_LAST) && !rel_normal;

  assign busy = |gnt;

  // State and datapath registers; async reset also drops any live grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      gnt      <= '0;
      owner_id <= '0;
      timeout  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      gnt      <= gnt_nxt;
      owner_id <= owner_nxt;
      timeout  <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (pick_valid) state_nxt = ST_GRANTED;
      ST_GRANTED: if (rel_normal || rel_forced) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt     = gnt;
    owner_nxt   = owner_id;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_nxt           = '0;
          gnt_nxt[pick_idx] = 1'b1;
          owner_nxt         = pick_idx;
          cnt_nxt           = '0;
        end
      end
      ST_GRANTED: begin
        if (rel_normal || rel_forced) begin
          gnt_nxt     = '0;
          ptr_nxt     = (owner_id == PW'(N - 1)) ? '0 : owner_id + 1'b1;
          timeout_nxt = rel_forced;
        end else if (cnt != CNT_SAT) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: gnt_nxt = '0;
    endcase
  end

endmodule : arbiter_4_rr_sched

// File: tb/tb_arbiter_4_rr_sched.sv
// Randomized self-checking bench for arbiter_4_rr_sched against a cycle-level
// ownership model (owner index, cycles held, rotating priority start).
module tb_arbiter_4_rr_sched;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
  localparam int PW       = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  done = '0;
  logic [N-1:0]  gnt;
  logic          busy;
  logic [PW-1:0] owner_id;
  logic          timeout;

  int n_tests = 0;
  int n_fail  = 0;
  bit inv_on  = 1'b0;

  // Model: current owner (-1 when none), last owner, next priority start,
  // cycles the current owner has held, and the timeout pulse.
  int m_owner, m_last, m_ptr, m_held;
  bit m_to;

  arbiter_4_rr_sched #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .busy     (busy),
    .owner_id (owner_id),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
    bit normal, forced;
    if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_last  = m_owner;
          m_held  = 1;
        end
      end
    end else begin
      normal = d[m_owner] || !r[m_owner];
      forced = !normal && (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (normal || forced) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_to    = forced;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".owner"}, 32'(owner_id), 32'(m_last));
    check({tag, ".busy"}, 32'(busy), 32'(eg != 0));
    check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled likewise.
  task automatic step(input string tag, input logic [N-1:0] r, input logic [N-1:0] d);
    req  = r;
    done = d;
    model_edge(r, d);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [N-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    if (rst_n && inv_on) begin
      check("inv.onehot0", 32'($onehot0(gnt)), 32'd1);
      check("inv.busy", 32'(busy), 32'(|gnt));
      check("inv.handover", 32'(prev_gnt != 0 && gnt != 0 && gnt != prev_gnt), 32'd0);
    end
    prev_gnt <= gnt;
  end

  initial begin
    logic [N-1:0] seq_q[$];
    logic [N-1:0] exp_seq[9];
    int to_cnt;

    // Reset with all requesters asserted: nothing granted while held in reset.
    model_reset();
    req = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check("rst.gnt", 32'(gnt), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.timeout", 32'(timeout), 32'd0);
    check("rst.owner", 32'(owner_id), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    inv_on = 1'b1;
    step("rst.first", 4'b1111, 4'b0000);
    check("rst.first_grant", 32'(gnt), 32'h1);

    // Rotation with wrap: each owner holds two cycles then pulses done.
    apply_reset();
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    seq_q.delete();
    for (int s = 0; s < 40 && seq_q.size() < 9; s++) begin
      step("rot", 4'b1111, (m_owner >= 0 && m_held == 2) ? (N'(1) << m_owner) : '0);
      if (seq_q.size() == 0 ? (gnt != 0) : (gnt != seq_q[$])) seq_q.push_back(gnt);
    end
    check("rot.len", 32'(seq_q.size()), 32'd9);
    for (int i = 0; i < 9 && i < seq_q.size(); i++)
      check($sformatf("rot.seq%0d", i), 32'(seq_q[i]), 32'(exp_seq[i]));

    // Timeout: sole requester never finishes; expect forced releases.
    apply_reset();
    to_cnt = 0;
    for (int s = 0; s < 12; s++) begin
      step("to", 4'b0100, 4'b0000);
      if (timeout) to_cnt++;
    end
    check("to.pulses", 32'(to_cnt), 32'd2);

    // Done on the last allowed cycle is a normal release without timeout.
    apply_reset();
    step("sim.grant", 4'b0100, 4'b0000);
    for (int s = 0; s < 10 && m_held < MAX_HOLD; s++) step("sim.hold", 4'b0100, 4'b0000);
    step("sim.rel", 4'b0100, 4'b0100);
    check("sim.timeout", 32'(timeout), 32'd0);
    check("sim.gnt", 32'(gnt), 32'd0);

    // Non-owner request/done activity must not disturb the grant.
    apply_reset();
    step("noown.grant", 4'b1111, 4'b0000);
    for (int s = 0; s < 3; s++) begin
      step("noown", {3'($urandom), 1'b1}, {3'($urandom), 1'b0});
      check("noown.hold", 32'(gnt), 32'h1);
    end
    step("noown.rel", 4'b1111, 4'b0001);

    // Asynchronous reset in the middle of a grant.
    apply_reset();
    step("mid.grant", 4'b0010, 4'b0000);
    check("mid.gnt", 32'(gnt), 32'h2);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid.async_gnt", 32'(gnt), 32'd0);
    check("mid.async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("mid.after", 4'b0110, 4'b0000);
    check("mid.ptr0", 32'(gnt), 32'h2);

    // Random traffic: dense requests, sparse done strobes.
    apply_reset();
    for (int s = 0; s < 400; s++) begin
      logic [N-1:0] r, d;
      r = N'($urandom);
      for (int b = 0; b < N; b++) d[b] = ($urandom_range(0, 3) == 0);
      step("rand", r, d);
    end

    inv_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_arbiter_4_rr_sched
